// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: start/busy/done handshake and operand/result bus of the multiply/divide unit
interface alu_muldiv_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OPCODE_LENGTH = 3
);
  logic start;
  logic flush;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic busy;
  logic done;
  logic [DATA_WIDTH-1:0] Result;
  modport master (output start, flush, Operation, SrcA, SrcB, input busy, done, Result);
  modport slave (input start, flush, Operation, SrcA, SrcB, output busy, done, Result);
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit, one result bit per clock
module alu_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int OPCODE_LENGTH = 3
) (
  input logic clk,
  input logic reset,
  alu_muldiv_if.slave bus
);
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_n;
  logic [OPCODE_LENGTH-1:0] op;
  logic [CW-1:0] cnt;
  logic [W-1:0] m, result, abs_a, abs_b, quo, rem, sel;
  logic [2*W-1:0] acc, acc_n, prod;
  logic [W:0] sum, sh;
  logic [W+1:0] diff;
  logic na, nb, done, accept, is_div, sgn_a, sgn_b, neg_a, neg_b, div0, ovf, special;
  assign accept = state == IDLE && bus.start && !bus.flush;
  assign is_div = bus.Operation[2];
  assign sgn_a = is_div ? !bus.Operation[0] : bus.Operation[1:0] != 2'b11;
  assign sgn_b = is_div ? !bus.Operation[0] : !bus.Operation[1];
  assign neg_a = sgn_a && bus.SrcA[W-1];
  assign neg_b = sgn_b && bus.SrcB[W-1];
  assign abs_a = neg_a ? -bus.SrcA : bus.SrcA;
  assign abs_b = neg_b ? -bus.SrcB : bus.SrcB;
  assign div0 = is_div && bus.SrcB == '0;
  assign ovf = is_div && !bus.Operation[0] && bus.SrcA == {1'b1, {(W-1){1'b0}}} && &bus.SrcB;
  assign special = div0 || ovf;
  assign bus.busy = state != IDLE;
  assign bus.done = done;
  assign bus.Result = result;
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // next state: flush always wins, special divides skip the iteration
  always_comb begin
    state_n = state;
    if (bus.flush) state_n = IDLE;
    else if (state == IDLE) state_n = bus.start ? (special ? FIX : CALC) : IDLE;
    else if (state == CALC) state_n = cnt == CW'(1) ? FIX : CALC;
    else state_n = IDLE;
  end
  // one shift-add / restoring-divide step on acc, plus sign fix-up and result select
  always_comb begin
    sum = {1'b0, acc[2*W-1:W]} + {1'b0, m};
    sh = acc[2*W-1:W-1];
    diff = {1'b0, sh} - {2'b0, m};
    acc_n = op[2] ? (diff[W+1] ? {sh[W-1:0], acc[W-2:0], 1'b0} : {diff[W-1:0], acc[W-2:0], 1'b1})
                  : {acc[0] ? sum : {1'b0, acc[2*W-1:W]}, acc[W-1:1]};
    prod = na ^ nb ? -acc : acc;
    quo = na ^ nb ? -acc[W-1:0] : acc[W-1:0];
    rem = na ? -acc[2*W-1:W] : acc[2*W-1:W];
    sel = op[2] ? (op[1] ? rem : quo) : op[1:0] == 2'b00 ? prod[W-1:0] : prod[2*W-1:W];
  end
  // operand latch, iteration registers, result and done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op <= '0;
      cnt <= '0;
      m <= '0;
      acc <= '0;
      na <= 1'b0;
      nb <= 1'b0;
      done <= 1'b0;
      result <= '0;
    end else begin
      done <= state == FIX && !bus.flush;
      if (accept) begin
        op <= bus.Operation;
        na <= neg_a && !special;
        nb <= neg_b && !special;
        cnt <= CW'(W);
        m <= is_div ? abs_b : abs_a;
        acc <= div0 ? {bus.SrcA, {W{1'b1}}} : ovf ? {{W{1'b0}}, bus.SrcA} : {{W{1'b0}}, is_div ? abs_a : abs_b};
      end else if (state == CALC) begin
        cnt <= cnt - CW'(1);
        acc <= acc_n;
      end
      if (state == FIX && !bus.flush) result <= sel;
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: scoreboard bench for the multiply/divide unit at widths 32 and 8
module tb_alu_muldiv;
  typedef struct {logic [31:0] v; int due; string tag;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q32[$];
  exp_t q8[$];
  exp_t e;
  int want_busy = -1;
  int want_done = -1;
  bit want_chk_res = 1'b0;
  logic [31:0] want_res = '0;
  string want_tag = "";
  logic [31:0] last_res = '0;
  logic [2:0] d_op[12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
  logic [31:0] d_a[12] = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                           32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] d_b[12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd2, 32'd2,
                           32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] d_e[12] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                           32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};

  alu_muldiv_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) bus32 ();
  alu_muldiv_if #(.DATA_WIDTH(8), .OPCODE_LENGTH(3)) bus8 ();
  alu_muldiv #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  alu_muldiv #(.DATA_WIDTH(8), .OPCODE_LENGTH(3)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RV32M semantics from plain wide arithmetic, truncated to width w
  function automatic logic [31:0] ref_m(int w, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint mask, ua, ub, sa, sb, r;
    mask = (longint'(1) << w) - 1;
    ua = longint'({32'b0, a}) & mask;
    ub = longint'({32'b0, b}) & mask;
    sa = (ua << (64 - w)) >>> (64 - w);
    sb = (ub << (64 - w)) >>> (64 - w);
    case (op)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >>> w;
      3'd2: r = (sa * ub) >>> w;
      3'd3: r = longint'(($unsigned(ua) * $unsigned(ub)) >> w);
      3'd4: r = ub == 0 ? -1 : sa / sb;
      3'd5: r = ub == 0 ? -1 : ua / ub;
      3'd6: r = ub == 0 ? sa : sa % sb;
      default: r = ub == 0 ? ua : ua % ub;
    endcase
    return 32'(r & mask);
  endfunction

  function automatic bit is_spec(int w, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint mask, ua, ub;
    mask = (longint'(1) << w) - 1;
    ua = longint'({32'b0, a}) & mask;
    ub = longint'({32'b0, b}) & mask;
    return op[2] && (ub == 0 || (!op[0] && ua == (longint'(1) << (w - 1)) && ub == mask));
  endfunction

  function void cmp(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endfunction

  // monitor: pops the scoreboard on every done and serves point checks requested by the stimulus
  initial forever begin
    @(negedge clk);
    if (bus32.done) begin
      if (q32.size() == 0) cmp("done32_unexpected", 32'd1, 32'd0);
      else begin
        e = q32.pop_front();
        cmp({e.tag, "_res"}, bus32.Result, e.v);
        cmp({e.tag, "_lat"}, cyc, e.due);
      end
    end else if (q32.size() != 0 && cyc > q32[0].due) begin
      e = q32.pop_front();
      cmp({e.tag, "_timeout"}, cyc, e.due);
    end
    if (bus8.done) begin
      if (q8.size() == 0) cmp("done8_unexpected", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        cmp({e.tag, "_res"}, {24'b0, bus8.Result}, e.v);
        cmp({e.tag, "_lat"}, cyc, e.due);
      end
    end else if (q8.size() != 0 && cyc > q8[0].due) begin
      e = q8.pop_front();
      cmp({e.tag, "_timeout"}, cyc, e.due);
    end
    if (want_busy >= 0) cmp({want_tag, "_busy"}, 32'(bus32.busy), want_busy);
    if (want_done >= 0) cmp({want_tag, "_done"}, 32'(bus32.done), want_done);
    if (want_chk_res) cmp({want_tag, "_result"}, bus32.Result, want_res);
  end

  task automatic issue32(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] ev, bit push, string tag);
    bus32.Operation = op;
    bus32.SrcA = a;
    bus32.SrcB = b;
    bus32.start = 1'b1;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    if (push) begin
      q32.push_back('{ev, cyc + (is_spec(32, op, a, b) ? 1 : 33), tag});
      last_res = ev;
    end
  endtask

  task automatic issue8(logic [2:0] op, logic [7:0] a, logic [7:0] b, string tag);
    bus8.Operation = op;
    bus8.SrcA = a;
    bus8.SrcB = b;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    q8.push_back('{ref_m(8, op, {24'b0, a}, {24'b0, b}), cyc + (is_spec(8, op, {24'b0, a}, {24'b0, b}) ? 1 : 9), tag});
  endtask

  task automatic expect_now(int b, int d, bit cr, logic [31:0] r, string tag);
    want_busy = b;
    want_done = d;
    want_chk_res = cr;
    want_res = r;
    want_tag = tag;
    @(negedge clk);
    #1;
    want_busy = -1;
    want_done = -1;
    want_chk_res = 1'b0;
  endtask

  task automatic quiet(int n, logic [31:0] r, string tag);
    for (int i = 0; i < n; i++) expect_now(0, 0, 1'b1, r, tag);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q32.size() != 0 || q8.size() != 0 || bus32.busy || bus8.busy); i++) @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    int r;
    bus32.start = 1'b0;
    bus32.flush = 1'b0;
    bus32.Operation = '0;
    bus32.SrcA = '0;
    bus32.SrcB = '0;
    bus8.start = 1'b0;
    bus8.flush = 1'b0;
    bus8.Operation = '0;
    bus8.SrcA = '0;
    bus8.SrcB = '0;
    repeat (3) @(posedge clk);
    #1;
    expect_now(0, 0, 1'b1, 32'd0, "reset");
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      issue32(d_op[i], d_a[i], d_b[i], d_e[i], 1'b1, $sformatf("dir%0d", i));
      expect_now(1, -1, 1'b0, 32'd0, $sformatf("dir%0d", i));
      drain();
    end
    issue32(3'd0, 32'd1234, 32'd5678, 32'd7006652, 1'b1, "hold_mul");
    repeat (4) @(posedge clk);
    #1;
    issue32(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, "ign5");
    repeat (14) @(posedge clk);
    #1;
    issue32(3'd5, 32'd100, 32'd7, 32'd0, 1'b0, "ign20");
    drain();
    issue32(3'd5, 32'd100, 32'd7, 32'd14, 1'b1, "b2b_a");
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (bus32.done) break;
    end
    issue32(3'd7, 32'd100, 32'd7, 32'd2, 1'b1, "b2b_b");
    drain();
    issue32(3'd0, 32'd3, 32'd5, 32'd0, 1'b0, "flushed");
    repeat (9) @(posedge clk);
    #1;
    bus32.flush = 1'b1;
    @(posedge clk);
    #1;
    bus32.flush = 1'b0;
    quiet(30, 32'd2, "after_flush");
    bus32.flush = 1'b1;
    issue32(3'd5, 32'd9, 32'd3, 32'd0, 1'b0, "flush_start");
    bus32.flush = 1'b0;
    quiet(3, 32'd2, "flush_start");
    issue32(3'd5, 32'd9, 32'd3, 32'd3, 1'b1, "divu93");
    drain();
    issue32(3'd1, 32'h12345678, 32'h9ABCDEF0, 32'd0, 1'b0, "reset_victim");
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    expect_now(0, 0, 1'b1, 32'd0, "async_reset");
    reset = 1'b1;
    @(posedge clk);
    #1;
    quiet(35, 32'd0, "after_reset");
    issue32(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1, "post_reset");
    drain();
    for (int i = 0; i < 20; i++) begin
      op = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      a = r == 0 ? 32'h80000000 : $urandom;
      b = r < 2 ? 32'd0 : r < 4 ? 32'hFFFFFFFF : $urandom;
      issue32(op, a, b, ref_m(32, op, a, b), 1'b1, $sformatf("rnd32_%0d", i));
      drain();
    end
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      a = r == 0 ? 32'h80 : 32'($urandom_range(0, 255));
      b = r < 2 ? 32'd0 : r < 4 ? 32'hFF : 32'($urandom_range(0, 255));
      issue8(op, a[7:0], b[7:0], $sformatf("rnd8_%0d", i));
      drain();
    end
    drain();
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
